// File: rtl/fuzzy_edge_stream_if.sv
// Pixel-in / edge-out stream bundle for the fuzzy edge detector.
// The master drives pixels and mode. The slave returns edge results.
interface fuzzy_edge_stream_if #(
    parameter int unsigned PIX_W = 8
);
    logic             in_valid;
    logic [PIX_W-1:0] in_pix;
    logic             in_sof;
    logic [1:0]       mode;
    logic             out_valid;
    logic [PIX_W-1:0] out_edge;
    logic [PIX_W-1:0] out_grad;
    logic             out_sof;

    modport master (
        output in_valid, in_pix, in_sof, mode,
        input  out_valid, out_edge, out_grad, out_sof
    );

    modport slave (
        input  in_valid, in_pix, in_sof, mode,
        output out_valid, out_edge, out_grad, out_sof
    );
endinterface

// File: rtl/fuzzy_edge_stream.sv
// Streaming 3x3 fuzzy edge detector: two line buffers feed a window.
// A three-stage pipeline follows: window register, gradients, fuzzify/aggregate.
module fuzzy_edge_stream #(
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned IMG_H    = 480,
    parameter int unsigned T_LO     = 32,
    parameter int unsigned SLOPE_SH = 5
) (
    input  logic                clk,
    input  logic                rst,
    fuzzy_edge_stream_if.slave  io
);
    typedef enum logic [1:0] {
        MODE_FUZZY     = 2'd0,
        MODE_BINARY    = 2'd1,
        MODE_RAW       = 2'd2,
        MODE_FUZZY_ALT = 2'd3
    } mode_e;

    localparam int unsigned CW  = $clog2(IMG_W);
    localparam int unsigned RWD = $clog2(IMG_H);
    localparam int unsigned RW  = PIX_W + SLOPE_SH + 1;
    localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
    localparam logic [RWD-1:0]   ROW_LAST = RWD'(IMG_H - 1);
    localparam logic [PIX_W-1:0] MAXV     = '1;
    localparam logic [RW-1:0]    T_LO_W   = RW'(T_LO);
    localparam logic [RW-1:0]    RAMP     = RW'(1) << SLOPE_SH;
    localparam logic [PIX_W:0]   T_HI     = (PIX_W + 1)'(T_LO + (1 << SLOPE_SH));

    function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic logic [PIX_W-1:0] mu_high(input logic [PIX_W-1:0] d);
        logic [RW-1:0] dw, r, sc;
        dw = RW'(d);
        if (dw <= T_LO_W)             r = '0;
        else if (dw - T_LO_W >= RAMP) r = RAMP;
        else                          r = dw - T_LO_W;
        sc = (r << PIX_W) >> SLOPE_SH;
        return (sc > RW'(MAXV)) ? MAXV : sc[PIX_W-1:0];
    endfunction

    function automatic logic [PIX_W-1:0] mu_mid(input logic [PIX_W-1:0] rs);
        logic [PIX_W+1:0] t, m, a, res;
        t   = {1'b0, rs, 1'b0};
        m   = {2'b00, MAXV};
        a   = (t >= m) ? t - m : m - t;
        res = m - a;
        return res[PIX_W-1:0];
    endfunction

    logic [CW-1:0]    col_q, col_d, col_cur;
    logic [RWD-1:0]   row_q, row_d, row_cur;
    logic             win_ok, first_win;
    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];
    logic [PIX_W-1:0] top_q [2];
    logic [PIX_W-1:0] mid_q [2];
    logic [PIX_W-1:0] bot_q [2];
    logic [PIX_W-1:0] win_d [9];

    logic             v1_q, sof1_q, v2_q, sof2_q;
    mode_e            mode1_q, mode2_q;
    logic [PIX_W-1:0] z_q [9];
    logic [PIX_W-1:0] d_q [4];
    logic [PIX_W-1:0] maxd, h_agg, m_agg, edge_d;
    logic [PIX_W:0]   fuzzy_sum;
    logic             out_valid_q, out_sof_q;
    logic [PIX_W-1:0] out_edge_q, out_grad_q;

    // in_sof re-anchors the accepted pixel to (0,0); the row gate then suppresses cross-frame windows
    always_comb begin
        col_cur   = io.in_sof ? '0 : col_q;
        row_cur   = io.in_sof ? '0 : row_q;
        col_d     = col_q;
        row_d     = row_q;
        win_ok    = io.in_valid && (row_cur >= RWD'(2)) && (col_cur >= CW'(2));
        first_win = (row_cur == RWD'(2)) && (col_cur == CW'(2));
        if (io.in_valid) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RWD'(1);
            end else begin
                col_d = col_cur + CW'(1);
                row_d = row_cur;
            end
        end
        win_d = '{top_q[0], top_q[1], lb0_q[col_cur],
                  mid_q[0], mid_q[1], lb1_q[col_cur],
                  bot_q[0], bot_q[1], io.in_pix};
    end

    always_ff @(posedge clk) begin
        if (io.in_valid) begin
            lb0_q[col_cur] <= lb1_q[col_cur];
            lb1_q[col_cur] <= io.in_pix;
            top_q[0] <= top_q[1];
            top_q[1] <= lb0_q[col_cur];
            mid_q[0] <= mid_q[1];
            mid_q[1] <= lb1_q[col_cur];
            bot_q[0] <= bot_q[1];
            bot_q[1] <= io.in_pix;
        end
    end

    always_comb begin
        maxd  = '0;
        h_agg = '0;
        m_agg = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (d_q[k] > maxd)                  maxd  = d_q[k];
            if (mu_high(d_q[k]) > h_agg)        h_agg = mu_high(d_q[k]);
            if (mu_mid(mu_high(d_q[k])) > m_agg) m_agg = mu_mid(mu_high(d_q[k]));
        end
        fuzzy_sum = {1'b0, h_agg} + {2'b00, m_agg[PIX_W-1:1]};
        case (mode2_q)
            MODE_BINARY: edge_d = ({1'b0, maxd} >= T_HI) ? MAXV : '0;
            MODE_RAW:    edge_d = maxd;
            default:     edge_d = fuzzy_sum[PIX_W] ? MAXV : fuzzy_sum[PIX_W-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            v1_q        <= 1'b0;
            sof1_q      <= 1'b0;
            mode1_q     <= MODE_FUZZY;
            z_q         <= '{default: '0};
            v2_q        <= 1'b0;
            sof2_q      <= 1'b0;
            mode2_q     <= MODE_FUZZY;
            d_q         <= '{default: '0};
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_edge_q  <= '0;
            out_grad_q  <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            v1_q   <= win_ok;
            if (win_ok) begin
                z_q     <= win_d;
                mode1_q <= mode_e'(io.mode);
                sof1_q  <= first_win;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                d_q[0]  <= absdiff(z_q[0], z_q[8]);
                d_q[1]  <= absdiff(z_q[1], z_q[7]);
                d_q[2]  <= absdiff(z_q[2], z_q[6]);
                d_q[3]  <= absdiff(z_q[3], z_q[5]);
                mode2_q <= mode1_q;
                sof2_q  <= sof1_q;
            end
            out_valid_q <= v2_q;
            if (v2_q) begin
                out_edge_q <= edge_d;
                out_grad_q <= maxd;
                out_sof_q  <= sof2_q;
            end else begin
                out_sof_q  <= 1'b0;
            end
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.out_edge  = out_edge_q;
    assign io.out_grad  = out_grad_q;
    assign io.out_sof   = out_sof_q;
endmodule
